burst_master: RTL

BURST_MASTER -- requirements
Module: burst_master

---
 rtl/burst_master_if.sv | 42 ++++
 rtl/burst_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/burst_master_if.sv
// Command, AHB master and data-side signals of the burst master.
interface burst_master_if;
  logic        I_BM_CMD_VALID;
  logic        O_BM_CMD_READY;
  logic [31:0] I_BM_ADDR;
  logic [4:0]  I_BM_COUNT;
  logic [2:0]  I_BM_SIZE;
  logic        I_BM_WRITE;
  logic [31:0] O_BM_HADDR;
  logic [1:0]  O_BM_HTRANS;
  logic        O_BM_HWRITE;
  logic [2:0]  O_BM_HSIZE;
  logic [2:0]  O_BM_HBURST;
  logic [31:0] O_BM_HWDATA;
  logic [31:0] I_BM_HRDATA;
  logic        I_BM_HREADY;
  logic        I_BM_HRESP;
  logic [31:0] I_BM_WDATA;
  logic        O_BM_WPOP;
  logic [31:0] O_BM_RDATA;
  logic        O_BM_RVALID;
  logic        O_BM_DONE;
  logic        O_BM_ERR;

  // Burst master side
  modport master (
    input  I_BM_CMD_VALID, I_BM_ADDR, I_BM_COUNT, I_BM_SIZE, I_BM_WRITE,
           I_BM_HRDATA, I_BM_HREADY, I_BM_HRESP, I_BM_WDATA,
    output O_BM_CMD_READY, O_BM_HADDR, O_BM_HTRANS, O_BM_HWRITE, O_BM_HSIZE,
           O_BM_HBURST, O_BM_HWDATA, O_BM_WPOP, O_BM_RDATA, O_BM_RVALID,
           O_BM_DONE, O_BM_ERR
  );

  // Command source / AHB slave side
  modport slave (
    output I_BM_CMD_VALID, I_BM_ADDR, I_BM_COUNT, I_BM_SIZE, I_BM_WRITE,
           I_BM_HRDATA, I_BM_HREADY, I_BM_HRESP, I_BM_WDATA,
    input  O_BM_CMD_READY, O_BM_HADDR, O_BM_HTRANS, O_BM_HWRITE, O_BM_HSIZE,
           O_BM_HBURST, O_BM_HWDATA, O_BM_WPOP, O_BM_RDATA, O_BM_RVALID,
           O_BM_DONE, O_BM_ERR
  );
endinterface

// File: rtl/burst_master.sv
// AHB-lite INCR burst master: one command becomes COUNT pipelined beats.
module burst_master (
  input  logic           I_BM_HCLK,
  input  logic           I_BM_HRESET_N,
  burst_master_if.master bm
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_LAST, ST_ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d, next_addr;
  logic [1:0]          htrans_q, htrans_d;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic                rvalid_q, rvalid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                cmd_bad, err_start, wpop_c;

  assign cmd_bad   = (bm.I_BM_COUNT == '0) || (bm.I_BM_SIZE > 3'd2);
  assign next_addr = haddr_q + (ADDR_W'(1) << hsize_q);

  // Next-state, bus and pulse logic; beats_q counts address phases still to issue
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    beats_d  = beats_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wpop_c   = 1'b0;
    err_start = bm.I_BM_HRESP && !bm.I_BM_HREADY &&
                ((state_q == ST_DATA) || (state_q == ST_LAST));
    unique case (state_q)
      ST_IDLE: begin
        if (bm.I_BM_CMD_VALID && cmd_ready_q) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            haddr_d  = bm.I_BM_ADDR;
            htrans_d = HTRANS_NONSEQ;
            hsize_d  = bm.I_BM_SIZE;
            hwrite_d = bm.I_BM_WRITE;
            beats_d  = CNT_W'(bm.I_BM_COUNT - CNT_W'(1));
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR, ST_DATA: begin
        if (err_start) begin
          htrans_d = HTRANS_IDLE;
          err_d    = 1'b1;
          state_d  = ST_ERR;
        end else if (bm.I_BM_HREADY) begin
          if ((state_q == ST_DATA) && !hwrite_q && !bm.I_BM_HRESP) begin
            rvalid_d = 1'b1;
            rdata_d  = bm.I_BM_HRDATA;
          end
          if (hwrite_q) begin
            wpop_c   = 1'b1;
            hwdata_d = bm.I_BM_WDATA;
          end
          if (beats_q == '0) begin
            htrans_d = HTRANS_IDLE;
            state_d  = ST_LAST;
          end else begin
            haddr_d  = next_addr;
            // A beat landing on a 1 KB boundary must restart as NONSEQ
            htrans_d = (next_addr[9:0] == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            beats_d  = CNT_W'(beats_q - CNT_W'(1));
            state_d  = ST_DATA;
          end
        end
      end
      ST_LAST: begin
        if (err_start) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else if (bm.I_BM_HREADY) begin
          if (!hwrite_q && !bm.I_BM_HRESP) begin
            rvalid_d = 1'b1;
            rdata_d  = bm.I_BM_HRDATA;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (bm.I_BM_HREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready is withheld during the DONE cycle so back-to-back bursts are two cycles apart
    cmd_ready_d = (state_d == ST_IDLE) && !done_d;
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge I_BM_HCLK) begin
    if (!I_BM_HRESET_N) begin
      state_q     <= ST_IDLE;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= HSIZE_WORD;
      hwdata_q    <= '0;
      rdata_q     <= '0;
      beats_q     <= '0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      rdata_q     <= rdata_d;
      beats_q     <= beats_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bm.O_BM_CMD_READY = cmd_ready_q;
  assign bm.O_BM_HADDR     = haddr_q;
  assign bm.O_BM_HTRANS    = htrans_q;
  assign bm.O_BM_HWRITE    = hwrite_q;
  assign bm.O_BM_HSIZE     = hsize_q;
  assign bm.O_BM_HBURST    = HBURST_INCR;
  assign bm.O_BM_HWDATA    = hwdata_q;
  // Pop must coincide with the completing write address phase, so it is combinational
  assign bm.O_BM_WPOP      = wpop_c;
  assign bm.O_BM_RDATA     = rdata_q;
  assign bm.O_BM_RVALID    = rvalid_q;
  assign bm.O_BM_DONE      = done_q;
  assign bm.O_BM_ERR       = err_q;
endmodule
